// File: rtl/uart_msg_tx.sv
// rtl/uart_msg_tx.sv - fixed-string message sequencer feeding a uart_tx byte transmitter
//
// Purpose:
//    Streams MSG (MSG_LEN characters, character 0 in the MSB byte) to an
//    external uart_tx using its start/ready handshake. Supports one-shot or
//    auto-repeat operation, an external trigger and an inter-message gap.
//    Optional feature macro: UART_MSG_CRLF_EN appends 8'h0D, 8'h0A to every message.
//
// Ports:
//    sys_clk   in   clock
//    rstn      in   synchronous active-low reset
//    trigger   in   start request, level-sampled in IDLE and END
//    tx_ready  in   uart_tx idle / able to accept a byte
//    tx_start  out  one-cycle byte start pulse to uart_tx
//    tx_data   out  byte to send, follows char_idx combinationally
//    busy      out  high whenever the sequencer is not IDLE
//    done      out  one-cycle pulse when the last character completes
//    char_idx  out  index of the current character
module uart_msg_tx #(
   parameter int                   MSG_LEN    = 8,
   parameter logic [8*MSG_LEN-1:0] MSG        = "Hello!..",
   parameter bit                   REPEAT     = 1'b0,
   parameter int                   GAP_CYCLES = 0
) (
   input  logic       sys_clk,
   input  logic       rstn,
   input  logic       trigger,
   input  logic       tx_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] char_idx
);

`ifdef UART_MSG_CRLF_EN
   localparam logic [7:0] LAST = 8'(MSG_LEN + 1);
`else
   localparam logic [7:0] LAST = 8'(MSG_LEN - 1);
`endif
   localparam logic [23:0] GAP_LOAD = 24'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_NEXT,
      S_GAP,
      S_END
   } state_t;

   state_t      state_q;
   logic [7:0]  char_idx_q;
   logic [23:0] gap_q;
   logic        tx_start_q;
   logic        done_q;
   logic        busy_q;

   // Outputs are registered alongside the state transition so that each one
   // is valid during the cycle the FSM spends in the matching state.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         char_idx_q <= 8'd0;
         gap_q      <= 24'd0;
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trigger && tx_ready) begin
                  state_q    <= S_SEND;
                  tx_start_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_SEND: begin
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!tx_ready) state_q <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (tx_ready) begin
                  state_q <= S_NEXT;
                  // done must be high during the NEXT cycle of the last character
                  done_q  <= (char_idx_q == LAST);
               end
            end
            S_NEXT: begin
               if (char_idx_q == LAST) begin
                  char_idx_q <= 8'd0;
                  if (GAP_CYCLES > 0) begin
                     state_q <= S_GAP;
                     gap_q   <= GAP_LOAD;
                  end else begin
                     state_q <= S_END;
                  end
               end else begin
                  char_idx_q <= char_idx_q + 8'd1;
                  state_q    <= S_SEND;
                  tx_start_q <= 1'b1;
               end
            end
            S_GAP: begin
               // GAP lasts exactly GAP_CYCLES cycles: leave as the counter reaches 0
               gap_q <= gap_q - 24'd1;
               if (gap_q <= 24'd1) state_q <= S_END;
            end
            S_END: begin
               if (REPEAT && trigger) begin
                  state_q    <= S_SEND;
                  tx_start_q <= 1'b1;
               end else if (!trigger) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      tx_data = 8'h2E;
      for (int i = 0; i < MSG_LEN; i++) begin
         if (char_idx_q == 8'(i)) tx_data = MSG[8*(MSG_LEN-i)-1 -: 8];
      end
`ifdef UART_MSG_CRLF_EN
      if (char_idx_q == 8'(MSG_LEN))     tx_data = 8'h0D;
      if (char_idx_q == 8'(MSG_LEN + 1)) tx_data = 8'h0A;
`endif
   end

   assign tx_start = tx_start_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign char_idx = char_idx_q;

endmodule
